// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : calc_pkg                                                  |
// | Purpose  : Shared command/response/state encodings for calc_n_core   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package calc_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_PEND = 2'd2
  } port_state_e;

endpackage
`default_nettype wire

// File: rtl/calc_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : calc_rr_arbiter                                           |
// | Purpose  : Round-robin arbiter, one-hot grant, pointer = last + 1    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module calc_rr_arbiter #(
  parameter int NPORT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NPORT-1:0]             i_req,
  output logic [NPORT-1:0]             o_gnt,
  output logic [$clog2(NPORT)-1:0]     o_gnt_idx,
  output logic                         o_gnt_vld
);

  localparam int c_PW = $clog2(NPORT);

  logic [c_PW-1:0] ptr_q;
  logic [c_PW-1:0] ptr_d;
  logic [c_PW-1:0] w_idx;

  // Scan from the pointer upward (wrapping) and take the first requester.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    w_idx     = '0;
    for (int i = 0; i < NPORT; i++) begin
      w_idx = c_PW'((int'(ptr_q) + i) % NPORT);
      if (!o_gnt_vld && i_req[w_idx]) begin
        o_gnt_vld    = 1'b1;
        o_gnt_idx    = w_idx;
        o_gnt[w_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (o_gnt_vld) begin
      ptr_d = (o_gnt_idx == c_PW'(NPORT - 1)) ? '0 : o_gnt_idx + c_PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/calc_n_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : calc_n_core                                               |
// | Purpose  : N-port two-cycle command capture, RR arbitration, shared  |
// |            add/sub/shift datapath with tagged per-port responses     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module calc_n_core
  import calc_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int W     = 32
) (
  input  logic                          c_clk,
  input  logic                          reset,
  input  logic [NPORT-1:0][3:0]         req_cmd_in,
  input  logic [NPORT-1:0][W-1:0]       req_data_in,
  output logic [NPORT-1:0][1:0]         out_resp,
  output logic [NPORT-1:0][W-1:0]       out_data
);

  localparam int c_PW  = $clog2(NPORT);
  localparam int c_SHW = $clog2(W);

  port_state_e               state_q [NPORT];
  port_state_e               state_d [NPORT];
  logic [NPORT-1:0][3:0]     cmd_q, cmd_d;
  logic [NPORT-1:0][W-1:0]   op1_q, op1_d;
  logic [NPORT-1:0][W-1:0]   op2_q, op2_d;
  logic [NPORT-1:0]          w_cap_op1, w_cap_op2, w_pend;

  logic [NPORT-1:0]          w_gnt;
  logic [c_PW-1:0]           w_gnt_idx;
  logic                      w_gnt_vld;

  logic                      ex_vld_q, ex_vld_d;
  logic [c_PW-1:0]           ex_port_q, ex_port_d;
  logic [3:0]                ex_cmd_q, ex_cmd_d;
  logic [W-1:0]              ex_op1_q, ex_op1_d;
  logic [W-1:0]              ex_op2_q, ex_op2_d;

  logic [W:0]                w_sum;
  logic [c_SHW-1:0]          w_shamt;
  resp_e                     w_res_resp;
  logic [W-1:0]              w_res_data;

  logic [NPORT-1:0][1:0]     resp_q, resp_d;
  logic [NPORT-1:0][W-1:0]   data_q, data_d;

  // Per-port capture FSM: state register
  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int p = 0; p < NPORT; p++) begin
        state_q[p] <= ST_IDLE;
      end
      cmd_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        state_q[p] <= state_d[p];
      end
      cmd_q <= cmd_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
    end
  end

  // Per-port capture FSM: next state
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      state_d[p] = state_q[p];
      case (state_q[p])
        ST_IDLE: if (req_cmd_in[p] != 4'd0) state_d[p] = ST_OP2;
        ST_OP2:  state_d[p] = ST_PEND;
        ST_PEND: if (w_gnt[p]) state_d[p] = ST_IDLE;
        default: state_d[p] = ST_IDLE;
      endcase
    end
  end

  // Per-port capture FSM: outputs. A cmd outside IDLE is never captured.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      w_cap_op1[p] = (state_q[p] == ST_IDLE) && (req_cmd_in[p] != 4'd0);
      w_cap_op2[p] = (state_q[p] == ST_OP2);
      w_pend[p]    = (state_q[p] == ST_PEND);
    end
  end

  always_comb begin
    cmd_d = cmd_q;
    op1_d = op1_q;
    op2_d = op2_q;
    for (int p = 0; p < NPORT; p++) begin
      if (w_cap_op1[p]) begin
        cmd_d[p] = req_cmd_in[p];
        op1_d[p] = req_data_in[p];
      end
      if (w_cap_op2[p]) begin
        op2_d[p] = req_data_in[p];
      end
    end
  end

  calc_rr_arbiter #(
    .NPORT (NPORT)
  ) u_arb (
    .clk       (c_clk),
    .rst       (reset),
    .i_req     (w_pend),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  always_comb begin
    ex_vld_d  = w_gnt_vld;
    ex_port_d = w_gnt_idx;
    ex_cmd_d  = cmd_q[w_gnt_idx];
    ex_op1_d  = op1_q[w_gnt_idx];
    ex_op2_d  = op2_q[w_gnt_idx];
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      ex_vld_q  <= 1'b0;
      ex_port_q <= '0;
      ex_cmd_q  <= '0;
      ex_op1_q  <= '0;
      ex_op2_q  <= '0;
    end else begin
      ex_vld_q  <= ex_vld_d;
      ex_port_q <= ex_port_d;
      ex_cmd_q  <= ex_cmd_d;
      ex_op1_q  <= ex_op1_d;
      ex_op2_q  <= ex_op2_d;
    end
  end

  // Unsigned datapath; any error forces the result data to zero.
  always_comb begin
    w_sum      = {1'b0, ex_op1_q} + {1'b0, ex_op2_q};
    w_shamt    = ex_op2_q[c_SHW-1:0];
    w_res_resp = RESP_ERR;
    w_res_data = '0;
    case (ex_cmd_q)
      CMD_ADD: begin
        if (!w_sum[W]) begin
          w_res_resp = RESP_OK;
          w_res_data = w_sum[W-1:0];
        end
      end
      CMD_SUB: begin
        if (ex_op1_q >= ex_op2_q) begin
          w_res_resp = RESP_OK;
          w_res_data = ex_op1_q - ex_op2_q;
        end
      end
      CMD_SHL: begin
        w_res_resp = RESP_OK;
        w_res_data = ex_op1_q << w_shamt;
      end
      CMD_SHR: begin
        w_res_resp = RESP_OK;
        w_res_data = ex_op1_q >> w_shamt;
      end
      default: begin
        w_res_resp = RESP_ERR;
        w_res_data = '0;
      end
    endcase
  end

  always_comb begin
    resp_d = '0;
    data_d = '0;
    if (ex_vld_q) begin
      resp_d[ex_port_q] = w_res_resp;
      data_d[ex_port_q] = w_res_data;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      resp_q <= '0;
      data_q <= '0;
    end else begin
      resp_q <= resp_d;
      data_q <= data_d;
    end
  end

  assign out_resp = resp_q;
  assign out_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_n_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_calc_n_core                                            |
// | Purpose  : Scoreboard bench for calc_n_core (NPORT=4, W=32)          |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_calc_n_core;
  import calc_pkg::*;

  localparam int NPORT = 4;
  localparam int W     = 32;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NPORT-1:0][3:0]   req_cmd_in;
  logic [NPORT-1:0][W-1:0] req_data_in;
  logic [NPORT-1:0][1:0]   out_resp;
  logic [NPORT-1:0][W-1:0] out_data;

  typedef struct {
    string      name;
    int         port;
    logic [1:0] resp;
    logic [W-1:0] data;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   hit;

  calc_n_core #(
    .NPORT (NPORT),
    .W     (W)
  ) dut (
    .c_clk       (clk),
    .reset       (reset),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .out_resp    (out_resp),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response must match the oldest expectation for its port.
  always @(negedge clk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (out_resp[p] != 2'b00) begin
        hit = -1;
        foreach (sb[i]) if (hit < 0 && sb[i].port == p) hit = i;
        n_cmp++;
        if (hit < 0) begin
          n_fail++;
          $display("FAIL unexpected_resp port%0d: got resp=%0b data=%h cyc=%0d, want no response",
                   p, out_resp[p], out_data[p], cyc);
        end else begin
          if (out_resp[p] !== sb[hit].resp || out_data[p] !== sb[hit].data || cyc != sb[hit].due) begin
            n_fail++;
            $display("FAIL %s port%0d: got resp=%0b data=%h cyc=%0d, want resp=%0b data=%h cyc=%0d",
                     sb[hit].name, p, out_resp[p], out_data[p], cyc,
                     sb[hit].resp, sb[hit].data, sb[hit].due);
          end
          sb.delete(hit);
        end
      end else begin
        n_cmp++;
        if (out_data[p] !== '0) begin
          n_fail++;
          $display("FAIL idle_data port%0d: got data=%h cyc=%0d, want 0", p, out_data[p], cyc);
        end
      end
    end
  end

  task automatic push(input string name, input int p, input logic [1:0] r,
                      input logic [W-1:0] d, input int due);
    exp_t e;
    e.name = name; e.port = p; e.resp = r; e.data = d; e.due = due;
    sb.push_back(e);
  endtask

  // Two-cycle issue on one port; expected response at cmd edge + 3.
  task automatic issue1(input string name, input int p, input logic [3:0] cmd,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] er, input logic [W-1:0] ed);
    @(negedge clk);
    req_cmd_in[p]  = cmd;
    req_data_in[p] = a;
    push(name, p, er, ed, cyc + 1 + 3);
    @(negedge clk);
    req_cmd_in[p]  = 4'd0;
    req_data_in[p] = b;
    @(negedge clk);
    req_data_in[p] = '0;
  endtask

  // All ports ADD base+p in the same cycle; service in port order from 0.
  task automatic burst(input string name, input logic [W-1:0] base);
    @(negedge clk);
    for (int p = 0; p < NPORT; p++) begin
      req_cmd_in[p]  = CMD_ADD;
      req_data_in[p] = base;
      push(name, p, RESP_OK, base + W'(p), cyc + 1 + 3 + p);
    end
    @(negedge clk);
    for (int p = 0; p < NPORT; p++) begin
      req_cmd_in[p]  = 4'd0;
      req_data_in[p] = W'(p);
    end
    @(negedge clk);
    req_data_in = '0;
  endtask

  task automatic check_idle(input string name);
    n_cmp++;
    if (out_resp !== '0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL %s: got resp=%h data=%h, want all zero", name, out_resp, out_data);
    end
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle(name);
  endtask

  initial begin
    req_cmd_in  = '0;
    req_data_in = '0;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    reset = 1'b0;

    issue1("sub_10_3",   0, CMD_SUB, 32'd10,          32'd3,          RESP_OK,  32'd7);
    issue1("sub_3_10",   0, CMD_SUB, 32'd3,           32'd10,         RESP_ERR, 32'd0);
    issue1("sub_eq",     0, CMD_SUB, 32'd5,           32'd5,          RESP_OK,  32'd0);
    issue1("add_ovf",    0, CMD_ADD, 32'hFFFF_FFFF,   32'd1,          RESP_ERR, 32'd0);
    issue1("add_max",    0, CMD_ADD, 32'hFFFF_FFFE,   32'd1,          RESP_OK,  32'hFFFF_FFFF);
    issue1("shl_1_x25",  0, CMD_SHL, 32'd1,           32'h0000_0025,  RESP_OK,  32'h20);
    issue1("shr_msb_31", 0, CMD_SHR, 32'h8000_0000,   32'd31,         RESP_OK,  32'd1);
    issue1("cmd3_inv",   0, 4'd3,    32'd9,           32'd9,          RESP_ERR, 32'd0);
    issue1("cmd15_inv",  3, 4'd15,   32'd1,           32'd1,          RESP_ERR, 32'd0);
    repeat (6) @(negedge clk);

    pulse_reset("reset_before_burst");
    burst("burst1", 32'd1);
    repeat (6) @(negedge clk);
    burst("burst2", 32'd10);
    repeat (8) @(negedge clk);

    // Port 1 stays PEND behind port 0; its cmd sampled in PEND is dropped.
    @(negedge clk);
    req_cmd_in[0] = CMD_ADD; req_data_in[0] = 32'd5;
    req_cmd_in[1] = CMD_ADD; req_data_in[1] = 32'd6;
    push("drop_p0", 0, RESP_OK, 32'd12, cyc + 1 + 3);
    push("drop_p1", 1, RESP_OK, 32'd14, cyc + 1 + 4);
    @(negedge clk);
    req_cmd_in[0] = 4'd0; req_data_in[0] = 32'd7;
    req_cmd_in[1] = 4'd0; req_data_in[1] = 32'd8;
    @(negedge clk);
    req_data_in[0] = '0;
    req_cmd_in[1]  = CMD_SUB; req_data_in[1] = 32'd100;
    @(negedge clk);
    req_cmd_in[1]  = 4'd0; req_data_in[1] = 32'd1;
    @(negedge clk);
    req_data_in[1] = '0;
    repeat (8) @(negedge clk);

    // Reset lands on the edge that would load the execute stage.
    @(negedge clk);
    req_cmd_in[2] = CMD_SUB; req_data_in[2] = 32'd20;
    @(negedge clk);
    req_cmd_in[2] = 4'd0; req_data_in[2] = 32'd5;
    @(negedge clk);
    req_data_in[2] = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset_inflight");
    repeat (5) @(negedge clk);
    check_idle("after_discard");
    issue1("add_2_2", 2, CMD_ADD, 32'd2, 32'd2, RESP_OK, 32'd4);
    repeat (10) @(negedge clk);

    foreach (sb[i]) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s port%0d: got no response, want resp=%0b data=%h cyc=%0d",
               sb[i].name, sb[i].port, sb[i].resp, sb[i].data, sb[i].due);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/calc_n_core.md
# calc_n_core

Parametrised successor to the four-port calc1 arithmetic unit. Each of `NPORT` requester ports issues a two-cycle command (command + operand 1, then operand 2). A round-robin arbiter feeds a single shared add/subtract/shift datapath, which returns one tagged response per accepted command to the issuing port. Overflow, underflow and invalid commands are reported explicitly. The block replaces the fixed-width, fixed-port calc1 core in the verification environment and in the top-level integration.

## Interface
- `NPORT`, 4: number of requester ports (2..8)
- `W`, 32: operand/result width in bits (8..64, power of two)
- `c_clk` in 1: clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `req_cmd_in` in `NPORT`x4: per-port command
- `req_data_in` in `NPORT`x`W`: per-port operand bus
- `out_resp` in→out `NPORT`x2: per-port response (00 none, 01 success, 10 overflow/underflow/invalid, 11 never driven)
- `out_data` out `NPORT`x`W`: per-port result, valid only while `out_resp`=01

## Operation
- Commands:
  - 0 no-op
  - 1 add
  - 2 subtract
  - 5 shift left
  - 6 shift right (logical)
  - any other nonzero value is invalid and responds 10 with data 0.
- Issue protocol:
  - Cycle T: nonzero cmd with operand 1 on `req_data_in`.
  - Cycle T+1: operand 2, with cmd = 0.
  - A nonzero cmd at T+1 is treated as operand-2 data; the cmd value is ignored.
- One outstanding command per port.
  - A nonzero cmd while that port is capturing or pending is dropped silently and produces no response.
  - A port may issue again in the cycle its response appears.
- Per-port FSM: IDLE → OP2 (cmd sampled) → PEND (operand 2 sampled) → IDLE (granted).
- Arbiter:
  - One grant per cycle among PEND ports.
  - Round-robin, with priority pointer = last granted + 1 (mod `NPORT`).
  - Pointer resets to port 0.
- Arithmetic, all unsigned at width `W`:
  - Add: carry-out → resp 10, data 0.
  - Subtract: op1 < op2 → resp 10, data 0. op1 == op2 → resp 01, data 0.
  - Shift amount: op2[log2(W)-1:0]; upper bits ignored. Shifts never error.
- Response is routed only to the granted port, lasts exactly one cycle, then returns to 00 with data 0.

## Timing
- Reset:
  - On any edge with `reset`=1, all port FSMs go to IDLE, pending operands clear, in-flight operations are discarded (no response ever), and the arbiter pointer goes to 0.
  - All `out_resp`=00 and `out_data`=0 from the first reset edge onward.
- Minimum latency: cmd sampled at edge T, grant evaluated after edge T+1, execute register loaded at edge T+2, response register loaded at edge T+3. Response is visible from T+3 to T+4.
- Under contention, each waiting port adds one cycle per earlier grant. Worst case is T+3+(`NPORT`-1).
- Simultaneous PEND on all ports: grants go in pointer order, one per cycle, no starvation.
- Reset released at edge R: a cmd sampled at edge R+1 is accepted.

## Structure
- `calc_pkg` holds:
  - cmd enum (`CMD_NOP`, `CMD_ADD`, `CMD_SUB`, `CMD_SHL`, `CMD_SHR`)
  - resp enum (`RESP_NONE`, `RESP_OK`, `RESP_ERR`)
  - per-port FSM state enum
- Sub-module `calc_rr_arbiter`, parametrised by `NPORT`: request vector in, one-hot grant out, pointer register inside.
- Datapath and per-port capture FSMs live in `calc_n_core`.

## Test plan
- Single port, `W`=32: port 0 SUB 10−3 → `out_resp`[0]=01, data 7, exactly 3 cycles after cmd edge. SUB 3−10 → resp 10, data 0.
- ADD 0xFFFF_FFFF + 1 → resp 10, data 0. ADD 0xFFFF_FFFE + 1 → resp 01, data 0xFFFF_FFFF.
- SHL 1 by op2=0x0000_0025 (amount 5) → 0x20. SHR 0x8000_0000 by 31 → 1. Cmd 3 → resp 10, data 0.
- All 4 ports issue ADD 1+p in the same cycle → responses on ports 0, 1, 2, 3 at latency 3, 4, 5, 6. A second simultaneous burst is served starting at port 0 (pointer wrapped).
- Port 1 issues a new cmd while PEND → the second cmd gets no response; the first completes correctly.
- `reset` asserted for one cycle at T+2 of an in-flight SUB → no response, outputs 00/0. A new ADD 2+2 issued after release → 4.
